// File: rtl/rv32m_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, stall while busy.
// Define RV32M_FAST_MUL_EN to resolve MUL* ops in a single cycle with a combinational multiplier.
module rv32m_muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t          state;
  logic [2:0]      opReg;
  logic [4:0]      rdReg;
  logic [CNT_W-1:0] count;
  logic [XLEN-1:0] hiReg;
  logic [XLEN-1:0] loReg;
  logic [XLEN-1:0] opB;
  logic            negReg;

  logic            isDivIn, aSignedIn, bSignedIn, aNegIn, bNegIn, negIn;
  logic            divZero, divOvf, fastMul;
  logic [XLEN-1:0] aMagIn, bMagIn, specialResult, fastResult;

  always_comb begin
    isDivIn   = funct3[2];
    // MULH (01) and MULHSU (10) treat A as signed; only MULH treats B as signed.
    aSignedIn = isDivIn ? ~funct3[0] : (funct3[1] ^ funct3[0]);
    bSignedIn = isDivIn ? ~funct3[0] : (funct3[1:0] == 2'b01);
    aNegIn    = aSignedIn & rs1_val[XLEN-1];
    bNegIn    = bSignedIn & rs2_val[XLEN-1];
    aMagIn    = aNegIn ? -rs1_val : rs1_val;
    bMagIn    = bNegIn ? -rs2_val : rs2_val;
    negIn     = (isDivIn & funct3[1]) ? aNegIn : (aNegIn ^ bNegIn);
    divZero   = isDivIn & (rs2_val == '0);
    divOvf    = isDivIn & ~funct3[0] & (rs1_val == MIN_NEG) & (rs2_val == '1);
    if (divZero)
      specialResult = funct3[1] ? rs1_val : '1;
    else
      specialResult = funct3[1] ? '0 : MIN_NEG;
  end

`ifdef RV32M_FAST_MUL_EN
  logic signed [XLEN:0]     fastA, fastB;
  logic signed [2*XLEN-1:0] fastProd;
  assign fastA      = {aSignedIn & rs1_val[XLEN-1], rs1_val};
  assign fastB      = {bSignedIn & rs2_val[XLEN-1], rs2_val};
  assign fastProd   = (2*XLEN)'(fastA) * (2*XLEN)'(fastB);
  assign fastMul    = ~funct3[2];
  assign fastResult = (funct3[1:0] == 2'b00) ? fastProd[XLEN-1:0] : fastProd[2*XLEN-1:XLEN];
`else
  assign fastMul    = 1'b0;
  assign fastResult = '0;
`endif

  // hiReg/loReg hold {accumulator, multiplier} for multiply and {remainder, dividend} for divide.
  logic [XLEN:0]     mulSum, divShift;
  logic              divFits;
  logic [XLEN-1:0]   mulHiNext, mulLoNext, remNext, quotNext, finalResult;
  logic [2*XLEN-1:0] prodSigned;

  always_comb begin
    mulSum     = {1'b0, hiReg} + (loReg[0] ? {1'b0, opB} : '0);
    mulHiNext  = mulSum[XLEN:1];
    mulLoNext  = {mulSum[0], loReg[XLEN-1:1]};
    divShift   = {hiReg, loReg[XLEN-1]};
    divFits    = divShift >= {1'b0, opB};
    remNext    = divFits ? XLEN'(divShift - {1'b0, opB}) : divShift[XLEN-1:0];
    quotNext   = {loReg[XLEN-2:0], divFits};
    prodSigned = negReg ? -{mulHiNext, mulLoNext} : {mulHiNext, mulLoNext};
    if (opReg[2]) begin
      if (opReg[1])
        finalResult = negReg ? -remNext : remNext;
      else
        finalResult = negReg ? -quotNext : quotNext;
    end else begin
      finalResult = (opReg[1:0] == 2'b00) ? prodSigned[XLEN-1:0] : prodSigned[2*XLEN-1:XLEN];
    end
  end

  assign stall = busy | (start & (state == IDLE));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      opReg  <= '0;
      rdReg  <= '0;
      count  <= '0;
      hiReg  <= '0;
      loReg  <= '0;
      opB    <= '0;
      negReg <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      rd_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            opReg  <= funct3;
            rdReg  <= rd_in;
            negReg <= negIn;
            opB    <= bMagIn;
            loReg  <= aMagIn;
            hiReg  <= '0;
            count  <= '0;
            if (divZero | divOvf | fastMul) begin
              state  <= FIN;
              done   <= 1'b1;
              result <= (divZero | divOvf) ? specialResult : fastResult;
              rd_out <= rd_in;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end
        end
        RUN: begin
          count <= count + 1'b1;
          if (opReg[2]) begin
            hiReg <= remNext;
            loReg <= quotNext;
          end else begin
            hiReg <= mulHiNext;
            loReg <= mulLoNext;
          end
          if (count == CNT_W'(XLEN-1)) begin
            state  <= FIN;
            busy   <= 1'b0;
            done   <= 1'b1;
            result <= finalResult;
            rd_out <= rdReg;
          end
        end
        FIN: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32m_muldiv_unit.sv
// Self-checking bench for rv32m_muldiv_unit: directed RV32M cases, reset/ignored-start checks, random ops vs. arithmetic model.
module tb_rv32m_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] rs1_val = '0;
  logic [31:0] rs2_val = '0;
  logic [4:0]  rd_in = '0;
  logic        busy, stall, done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int testCount = 0;
  int failCount = 0;

  rv32m_muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .rd_in(rd_in),
    .busy(busy), .stall(stall), .done(done), .result(result), .rd_out(rd_out)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testCount++;
    if (got !== exp) begin
      failCount++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference results straight from the RV32M arithmetic rules, using 64-bit integers.
  function automatic logic [31:0] refModel(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub, p;
    logic [63:0] bits;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    case (f)
      3'd0: begin p = ua * ub; bits = p; return bits[31:0]; end
      3'd1: begin p = sa * sb; bits = p; return bits[63:32]; end
      3'd2: begin p = sa * ub; bits = p; return bits[63:32]; end
      3'd3: begin p = ua * ub; bits = p; return bits[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        p = sa / sb; bits = p; return bits[31:0];
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFFFFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 32'd0) return a;
        p = sa % sb; bits = p; return bits[31:0];
      end
      default: begin
        if (b == 32'd0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic int expLatency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && (b == 32'd0 || (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF)))
      return 1;
`ifdef RV32M_FAST_MUL_EN
    if (!f[2]) return 1;
`endif
    return 33;
  endfunction

  task automatic doOp(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] rd, input logic [31:0] expRes, input int glitchAt);
    int cycles;
    int extraDone;
    int expLat;
    string tagInfo;
    expLat  = expLatency(f, a, b);
    tagInfo = $sformatf("f3=%0d a=%h b=%h", f, a, b);
    @(posedge clk); #1;
    start = 1'b1; funct3 = f; rs1_val = a; rs2_val = b; rd_in = rd;
    #1 checkVal({"stall_issue ", tagInfo}, {31'd0, stall}, 32'd1);
    @(posedge clk); #1;
    start = 1'b0;
    rs1_val = $urandom; rs2_val = $urandom; funct3 = 3'($urandom); rd_in = 5'($urandom);
    cycles = 1;
    if (expLat > 1) checkVal({"busy_run ", tagInfo}, {31'd0, busy}, 32'd1);
    while (!done && cycles < 100) begin
      if (cycles == glitchAt) begin
        start = 1'b1; funct3 = 3'd4; rs1_val = $urandom; rs2_val = 32'd1; rd_in = 5'd17;
      end
      @(posedge clk); #1;
      start = 1'b0;
      cycles++;
    end
    checkVal({"latency ", tagInfo}, 32'(cycles), 32'(expLat));
    checkVal({"result ", tagInfo}, result, expRes);
    checkVal({"rd_out ", tagInfo}, {27'd0, rd_out}, {27'd0, rd});
    checkVal({"busy_fin ", tagInfo}, {31'd0, busy}, 32'd0);
    checkVal({"stall_fin ", tagInfo}, {31'd0, stall}, 32'd0);
    extraDone = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (done) extraDone++;
    end
    checkVal({"done_pulse ", tagInfo}, 32'(extraDone), 32'd0);
    $display("[TB] op f3=%0d a=%h b=%h rd=%0d -> result=%h lat=%0d", f, a, b, rd, result, cycles);
  endtask

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t dirVecs[11] = '{
    '{3'd0, 32'd7,         32'hFFFFFFFD, 32'hFFFFFFEB},
    '{3'd1, 32'h80000000,  32'h80000000, 32'h40000000},
    '{3'd3, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'hFFFFFFFE},
    '{3'd2, 32'hFFFFFFFF,  32'd2,        32'hFFFFFFFF},
    '{3'd4, 32'hFFFFFFF9,  32'd2,        32'hFFFFFFFD},
    '{3'd6, 32'hFFFFFFF9,  32'd2,        32'hFFFFFFFF},
    '{3'd5, 32'd100,       32'd7,        32'd14},
    '{3'd5, 32'd5,         32'd0,        32'hFFFFFFFF},
    '{3'd7, 32'd5,         32'd0,        32'd5},
    '{3'd6, 32'h80000000,  32'hFFFFFFFF, 32'd0},
    '{3'd4, 32'h80000000,  32'hFFFFFFFF, 32'h80000000}
  };

  initial begin
    int staleDone;
    logic [2:0]  rf;
    logic [31:0] ra, rb;
    int kind;

    repeat (3) @(posedge clk);
    #1;
    checkVal("reset_busy",   {31'd0, busy},   32'd0);
    checkVal("reset_done",   {31'd0, done},   32'd0);
    checkVal("reset_result", result,          32'd0);
    checkVal("reset_rd_out", {27'd0, rd_out}, 32'd0);
    checkVal("reset_stall",  {31'd0, stall},  32'd0);
    rst = 1'b0;

    for (int i = 0; i < 11; i++)
      doOp(dirVecs[i].f, dirVecs[i].a, dirVecs[i].b, 5'(i + 3), dirVecs[i].exp, 0);

    // Reset in the middle of an iterative divide.
    @(posedge clk); #1;
    start = 1'b1; funct3 = 3'd4; rs1_val = 32'd1000; rs2_val = 32'd3; rd_in = 5'd9;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    checkVal("midrst_busy_before", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    checkVal("midrst_busy",   {31'd0, busy},   32'd0);
    checkVal("midrst_done",   {31'd0, done},   32'd0);
    checkVal("midrst_result", result,          32'd0);
    checkVal("midrst_rd_out", {27'd0, rd_out}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    staleDone = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) staleDone++;
    end
    checkVal("midrst_stale_done", 32'(staleDone), 32'd0);
    $display("[TB] reset during DIV: outputs cleared, stale done pulses=%0d", staleDone);
    doOp(3'd5, 32'd1000, 32'd3, 5'd9, 32'd333, 0);

    // Second start during RUN must be ignored; also exercises rd=0.
    doOp(3'd0, 32'd12345, 32'd678, 5'd0, 32'd8369910, 5);

    for (int i = 0; i < 40; i++) begin
      kind = int'($urandom_range(0, 5));
      rf = 3'($urandom);
      ra = $urandom;
      rb = $urandom;
      if (kind == 0) rb = 32'd0;
      else if (kind == 1) begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
      else if (kind == 2) rb = 32'($urandom_range(1, 300)) * (($urandom & 1) != 0 ? 32'hFFFFFFFF : 32'd1);
      doOp(rf, ra, rb, 5'($urandom), refModel(rf, ra, rb), 0);
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
